// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counter family.
//   CNT_UP / CNT_DOWN : direction encodings for the UP input.
//   mod_next()        : next value of a modulo counter, evaluated in 33 bits
//                       so a modulus of 2**32 still fits without overflow.
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // value is assumed < modulus; modulus is at least 2.
    function automatic logic [32:0] mod_next(input logic [32:0] value,
                                             input logic        up,
                                             input logic [32:0] modulus);
        logic [32:0] res;
        if (up == CNT_UP) begin
            res = (value == modulus - 33'd1) ? 33'd0 : value + 33'd1;
        end else begin
            res = (value == 33'd0) ? modulus - 33'd1 : value - 33'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_mod_step.sv
// counter_mod_step
//   Combinational next-value and terminal-count detection for a modulo
//   up/down counter.
//   Ports:
//     cnt_i  : current count (always < MODULUS)
//     up_i   : direction, CNT_UP or CNT_DOWN
//     nxt_o  : count after one step in the selected direction
//     term_o : current count is the terminal value for that direction,
//              i.e. the step performs a wrap
module counter_mod_step
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             term_o
);

    localparam logic [32:0] MOD33  = 33'(MODULUS);
    localparam logic [32:0] LAST33 = 33'(MODULUS - 1);

    logic [32:0] cnt_ext;

    always_comb begin
        cnt_ext = 33'(cnt_i);
        // mod_next never produces a value >= MODULUS, so the truncation
        // back to WIDTH bits is lossless.
        nxt_o   = WIDTH'(mod_next(cnt_ext, up_i, MOD33));
        term_o  = (up_i == CNT_UP) ? (cnt_ext == LAST33) : (cnt_ext == 33'd0);
    end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
//   Synchronous modulo up/down counter with load, terminal-count strobe and
//   sticky wrap flag.
//   Parameters: WIDTH (1..32), MODULUS (2..2**WIDTH), INIT (< MODULUS).
//   Ports:
//     CLK    : clock, rising edge
//     RESETN : synchronous active-low reset (O <= INIT, OVF <= 0)
//     CE     : count enable
//     UP     : direction, 1 = increment
//     LD     : parallel load, DATA clamped to MODULUS-1
//     DATA   : load value
//     O      : registered count
//     COUT   : combinational strobe, high in the cycle whose edge wraps O
//     OVF    : registered sticky wrap flag, cleared by reset or load
//   Edge priority: reset, then load, then count, then hold.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter longint INIT    = 0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             OVF
);

    // Reject illegal parameter combinations at elaboration.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "counter_updown_mod: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_mod
            $fatal(1, "counter_updown_mod: MODULUS must be 2..2**WIDTH");
        end
        if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
            $fatal(1, "counter_updown_mod: INIT must be < MODULUS");
        end
    endgenerate

    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] LAST_W = WIDTH'(MODULUS - 1);
    localparam logic [32:0]      MOD33  = 33'(MODULUS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_term;
    logic [WIDTH-1:0] ld_val;

    counter_mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .cnt_i  (cnt_q),
        .up_i   (UP),
        .nxt_o  (step_nxt),
        .term_o (step_term)
    );

    always_comb begin
        // Compare in 33 bits so MODULUS = 2**WIDTH never clamps.
        ld_val = (33'(DATA) < MOD33) ? DATA : LAST_W;

        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (!RESETN) begin
            cnt_d = INIT_W;
            ovf_d = 1'b0;
        end else if (LD) begin
            cnt_d = ld_val;
            ovf_d = 1'b0;
        end else if (CE) begin
            cnt_d = step_nxt;
            ovf_d = ovf_q | step_term;
        end
    end

    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
    end

    // Strobe only when this edge really performs a wrap.
    assign COUT = CE & ~LD & RESETN & step_term;
    assign O    = cnt_q;
    assign OVF  = ovf_q;

endmodule
